sap1_control_sequencer: RTL
===========================

// Module: sap1_control_sequencer
// PURPOSE
//  Microcoded T-state controller for the SAP-1 datapath: fetches each instruction, decodes the IR opcode,
//  and drives every bus/load strobe, including the program counter's count/load/halt inputs.
//  Sits between the instruction register/flags and all datapath blocks. Outputs are Moore-decoded from
//  registered state so every strobe is glitch-free for a whole mclk_en-qualified cycle.
// PARAMETERS
//  OPCODE_WIDTH  4  width of i_opcode (upper IR nibble); opcodes outside the table below execute as NOP
//  STEP_WIDTH    3  width of the T-state counter / o_t_state (steps T0..T4 used)
// PORTS
//  mclk              in   1  system clock
//  rst_n             in   1  asynchronous active-low reset
//  mclk_en           in   1  clock enable; state advances only on mclk edges with mclk_en=1
//  i_opcode          in   OPCODE_WIDTH  IR opcode field, valid from T2 onward
//  i_flag_carry      in   1  registered carry flag
//  i_flag_zero       in   1  registered zero flag
//  o_t_state         out  STEP_WIDTH  current microstep (0..4)
//  o_pc_out/o_pc_count_enable/o_pc_load_enable   out 1 each  PC drive bus / increment / load from bus
//  o_halt            out  1  sticky halt, wired to PC i_halt and clock gating
//  o_mar_load, o_ram_out, o_ram_load, o_ir_load, o_ir_out        out 1 each  memory / IR strobes
//  o_a_load, o_a_out, o_b_load, o_alu_out, o_alu_sub, o_flags_load, o_out_load  out 1 each
// BEHAVIOUR
//  - While rst_n=0: t_state=0, halted=0, ALL outputs forced 0 (async). After release, T0 decode begins.
//  - Fetch (all opcodes): T0 pc_out+mar_load; T1 ram_out+ir_load+pc_count_enable.
//  - Execute (T2..), opcode -> strobes per step; after the last listed step next state is T0:
//    0x0 NOP : T2 none
//    0x1 LDA : T2 ir_out+mar_load; T3 ram_out+a_load
//    0x2 ADD : T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load
//    0x3 SUB : as ADD, with alu_sub also asserted in T3 and T4
//    0x4 STA : T2 ir_out+mar_load; T3 a_out+ram_load
//    0x5 LDI : T2 ir_out+a_load
//    0x6 JMP : T2 ir_out+pc_load_enable
//    0x7 JC  : T2 ir_out; pc_load_enable only if i_flag_carry=1 (sampled in T2)
//    0x8 JZ  : T2 ir_out; pc_load_enable only if i_flag_zero=1
//    0xE OUT : T2 a_out+out_load
//    0xF HLT : T2 o_halt asserted combinationally; halted reg set at end of T2
//    others  : NOP
//  - Instruction length = 2 fetch + execute steps: NOP/LDI/JMP/JC/JZ/OUT/HLT 3, LDA/STA 4, ADD/SUB 5 cycles.
//  - mclk_en=0: state frozen, outputs held at current decode (consumers qualify with mclk_en).
//  - Halted: o_halt=1, t_state frozen at 2, all other outputs 0; only rst_n clears it.
//  - At most one *_out strobe (pc/ram/ir/a/alu) asserted in any cycle; bus contention is a design error.
//  - Illegal t_state (5..7, e.g. SEU): next state T0, outputs 0.
//  - Reset mid-instruction: aborts immediately; next fetch starts at T0 (PC reset handled by PC).
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> all outputs 0, o_t_state=0; release -> cycle1 pc_out=mar_load=1.
//  2 LDA (i_opcode=1), mclk_en=1: t=0,1,2,3,0; T3 ram_out=a_load=1; no other strobes in any step.
//  3 SUB (i_opcode=3): 5-cycle sequence, T4 alu_out=a_load=flags_load=alu_sub=1, returns to T0.
//  4 JC with carry=0 then carry=1: T2 pc_load_enable=0 then 1; ir_out=1 both; both return to T0 after T2.
//  5 HLT then mclk_en toggling 1,0,1: stalls hold t_state; after T2 o_halt=1 permanently,
//    t_state stays 2, all strobes 0 for 20 cycles.
//  6 ADD with rst_n pulsed low mid-T3 (async) -> outputs 0 immediately; after release restart at T0.

Source files
------------

// File: rtl/sap1_control_sequencer_if.sv
// Signal bundle between the SAP-1 control sequencer and the datapath blocks it steers.
// The sequencer takes the master side; the IR/flags/datapath take the slave side.
interface sap1_control_sequencer_if #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
);
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic                    i_flag_carry;
  logic                    i_flag_zero;
  logic [STEP_WIDTH-1:0]   o_t_state;
  logic                    o_pc_out;
  logic                    o_pc_count_enable;
  logic                    o_pc_load_enable;
  logic                    o_halt;
  logic                    o_mar_load;
  logic                    o_ram_out;
  logic                    o_ram_load;
  logic                    o_ir_load;
  logic                    o_ir_out;
  logic                    o_a_load;
  logic                    o_a_out;
  logic                    o_b_load;
  logic                    o_alu_out;
  logic                    o_alu_sub;
  logic                    o_flags_load;
  logic                    o_out_load;

  modport master (
    input  i_opcode, i_flag_carry, i_flag_zero,
    output o_t_state, o_pc_out, o_pc_count_enable, o_pc_load_enable, o_halt,
    output o_mar_load, o_ram_out, o_ram_load, o_ir_load, o_ir_out,
    output o_a_load, o_a_out, o_b_load, o_alu_out, o_alu_sub, o_flags_load, o_out_load
  );

  modport slave (
    output i_opcode, i_flag_carry, i_flag_zero,
    input  o_t_state, o_pc_out, o_pc_count_enable, o_pc_load_enable, o_halt,
    input  o_mar_load, o_ram_out, o_ram_load, o_ir_load, o_ir_out,
    input  o_a_load, o_a_out, o_b_load, o_alu_out, o_alu_sub, o_flags_load, o_out_load
  );
endinterface

// File: rtl/sap1_control_sequencer.sv
// SAP-1 T-state sequencer: registered step counter and sticky halt, with the strobes
// decoded from that state plus the IR opcode and flags.
module sap1_control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic mclk_en,
  sap1_control_sequencer_if.master bus
);

  typedef enum logic [STEP_WIDTH-1:0] {
    T0 = STEP_WIDTH'(0),
    T1 = STEP_WIDTH'(1),
    T2 = STEP_WIDTH'(2),
    T3 = STEP_WIDTH'(3),
    T4 = STEP_WIDTH'(4)
  } step_t;

  typedef struct packed {
    logic pc_out;
    logic pc_count_enable;
    logic pc_load_enable;
    logic halt;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  step_t                   t_state;
  logic                    halted;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    is_alu_op;
  logic                    needs_t3;
  ctrl_t                   ctrl;

  assign opcode    = bus.i_opcode;
  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign needs_t3  = is_alu_op || (opcode == OP_LDA) || (opcode == OP_STA);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= T0;
      halted  <= 1'b0;
    end else if (mclk_en && !halted) begin
      case (t_state)
        T0: t_state <= T1;
        T1: t_state <= T2;
        T2: begin
          // HLT parks the counter at T2; the sticky flag then blocks all advance.
          if (opcode == OP_HLT)  halted  <= 1'b1;
          else if (needs_t3)     t_state <= T3;
          else                   t_state <= T0;
        end
        T3:      t_state <= is_alu_op ? T4 : T0;
        default: t_state <= T0;   // T4 and any corrupted encoding restart the fetch
      endcase
    end
  end

  // Strobes are gated by rst_n directly so they drop the moment reset asserts,
  // not at the next clock edge.
  always_comb begin
    // NOTE: defaulting the whole strobe set first keeps every path assigned,
    // so no latches are inferred for the steps/opcodes that drive nothing.
    ctrl = '0;
    if (rst_n) begin
      if (halted) begin
        ctrl.halt = 1'b1;
      end else begin
        case (t_state)
          T0: begin
            ctrl.pc_out   = 1'b1;
            ctrl.mar_load = 1'b1;
          end
          T1: begin
            ctrl.ram_out         = 1'b1;
            ctrl.ir_load         = 1'b1;
            ctrl.pc_count_enable = 1'b1;
          end
          T2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                ctrl.ir_out   = 1'b1;
                ctrl.mar_load = 1'b1;
              end
              OP_LDI: begin
                ctrl.ir_out = 1'b1;
                ctrl.a_load = 1'b1;
              end
              OP_JMP: begin
                ctrl.ir_out         = 1'b1;
                ctrl.pc_load_enable = 1'b1;
              end
              OP_JC: begin
                ctrl.ir_out         = 1'b1;
                ctrl.pc_load_enable = bus.i_flag_carry;
              end
              OP_JZ: begin
                ctrl.ir_out         = 1'b1;
                ctrl.pc_load_enable = bus.i_flag_zero;
              end
              OP_OUT: begin
                ctrl.a_out    = 1'b1;
                ctrl.out_load = 1'b1;
              end
              OP_HLT:  ctrl.halt = 1'b1;
              default: ;
            endcase
          end
          T3: begin
            if (opcode == OP_LDA) begin
              ctrl.ram_out = 1'b1;
              ctrl.a_load  = 1'b1;
            end else if (is_alu_op) begin
              ctrl.ram_out = 1'b1;
              ctrl.b_load  = 1'b1;
              ctrl.alu_sub = (opcode == OP_SUB);
            end else if (opcode == OP_STA) begin
              ctrl.a_out    = 1'b1;
              ctrl.ram_load = 1'b1;
            end
          end
          T4: begin
            if (is_alu_op) begin
              ctrl.alu_out    = 1'b1;
              ctrl.a_load     = 1'b1;
              ctrl.flags_load = 1'b1;
              ctrl.alu_sub    = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_t_state         = t_state;
  assign bus.o_pc_out          = ctrl.pc_out;
  assign bus.o_pc_count_enable = ctrl.pc_count_enable;
  assign bus.o_pc_load_enable  = ctrl.pc_load_enable;
  assign bus.o_halt            = ctrl.halt;
  assign bus.o_mar_load        = ctrl.mar_load;
  assign bus.o_ram_out         = ctrl.ram_out;
  assign bus.o_ram_load        = ctrl.ram_load;
  assign bus.o_ir_load         = ctrl.ir_load;
  assign bus.o_ir_out          = ctrl.ir_out;
  assign bus.o_a_load          = ctrl.a_load;
  assign bus.o_a_out           = ctrl.a_out;
  assign bus.o_b_load          = ctrl.b_load;
  assign bus.o_alu_out         = ctrl.alu_out;
  assign bus.o_alu_sub         = ctrl.alu_sub;
  assign bus.o_flags_load      = ctrl.flags_load;
  assign bus.o_out_load        = ctrl.out_load;

endmodule
